// File: rtl/nand2_sweep_checker.sv
// Stimulus/check stage for a 2-input NAND: on start, applies vectors 00..11, samples o
// in the last hold cycle of each vector and reports mismatch count, first failing vector, pass.
module nand2_sweep_checker #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned ERR_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             o,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_err_valid,
  output logic [1:0]       first_err_vec
);

  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [ERR_W-1:0] ErrMax = {ERR_W{1'b1}};

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [1:0]         vec_q, vec_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               pass_q, pass_d;
  logic               fev_q, fev_d;
  logic [1:0]         fvec_q, fvec_d;
  logic               mismatch;

  // vec_q drives a,b directly; it wraps 3->0 on the last sample so a,b return to 00.
  assign mismatch = (o != ~(vec_q[1] & vec_q[0]));

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    hold_d    = hold_q;
    err_cnt_d = err_cnt_q;
    pass_d    = pass_q;
    fev_d     = fev_q;
    fvec_d    = fvec_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          err_cnt_d = '0;
          pass_d    = 1'b0;
          fev_d     = 1'b0;
          fvec_d    = 2'd0;
          vec_d     = 2'd0;
          hold_d    = '0;
          state_d   = StRun;
        end
      end
      StRun: begin
        if (hold_q == HoldLast) begin
          hold_d = '0;
          vec_d  = vec_q + 2'd1;
          if (mismatch) begin
            if (err_cnt_q != ErrMax) err_cnt_d = err_cnt_q + ERR_W'(1);
            if (!fev_q) begin
              fev_d  = 1'b1;
              fvec_d = vec_q;
            end
          end
          if (vec_q == 2'd3) begin
            state_d = StDone;
            // Written here so pass is already valid in the done cycle.
            pass_d  = (err_cnt_d == '0);
          end
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      vec_q     <= 2'd0;
      hold_q    <= '0;
      err_cnt_q <= '0;
      pass_q    <= 1'b0;
      fev_q     <= 1'b0;
      fvec_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      hold_q    <= hold_d;
      err_cnt_q <= err_cnt_d;
      pass_q    <= pass_d;
      fev_q     <= fev_d;
      fvec_q    <= fvec_d;
    end
  end

  assign a               = vec_q[1];
  assign b               = vec_q[0];
  assign busy            = (state_q == StRun);
  assign done            = (state_q == StDone);
  assign pass            = pass_q;
  assign err_cnt         = err_cnt_q;
  assign first_err_valid = fev_q;
  assign first_err_vec   = fvec_q;

endmodule

// File: tb/tb_nand2_sweep_checker.sv
// Bench for nand2_sweep_checker: random gate truth tables, expected sweep results queued at
// start and checked by per-instance monitors when done pulses.
module tb_nand2_sweep_checker;

  localparam int unsigned H0 = 2, E0 = 3, H1 = 1, E1 = 1;

  typedef struct {
    int unsigned done_cyc;
    int unsigned err;
    bit          fv;
    bit [1:0]    fvec;
    bit          pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start0, start1;
  logic [3:0] tt0, tt1;
  logic o0, a0, b0, busy0, done0, pass0, fev0;
  logic [E0-1:0] ec0;
  logic [1:0] fvec0;
  logic o1, a1, b1, busy1, done1, pass1, fev1;
  logic [E1-1:0] ec1;
  logic [1:0] fvec1;

  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Gate under test modelled as a truth table indexed by {a,b}.
  assign o0 = tt0[{a0, b0}];
  assign o1 = tt1[{a1, b1}];

  nand2_sweep_checker #(.HOLD_CYCLES(H0), .ERR_W(E0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .o(o0), .a(a0), .b(b0), .busy(busy0),
    .done(done0), .pass(pass0), .err_cnt(ec0), .first_err_valid(fev0), .first_err_vec(fvec0)
  );

  nand2_sweep_checker #(.HOLD_CYCLES(H1), .ERR_W(E1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .o(o1), .a(a1), .b(b1), .busy(busy1),
    .done(done1), .pass(pass1), .err_cnt(ec1), .first_err_valid(fev1), .first_err_vec(fvec1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] tt, input int unsigned emax,
                                 input int unsigned c, input int unsigned h);
    exp_t e;
    int unsigned m = 0;
    e.fv = 1'b0;
    e.fvec = 2'd0;
    for (int v = 0; v < 4; v++) begin
      if (tt[v] !== (v != 3)) begin
        m++;
        if (!e.fv) begin
          e.fv = 1'b1;
          e.fvec = 2'(v);
        end
      end
    end
    e.err = (m > emax) ? emax : m;
    e.pass = (m == 0);
    e.done_cyc = c + 4 * h + 1;
    return e;
  endfunction

  task automatic wait_idle(input int id);
    int n = 0;
    @(negedge clk);
    while (id == 0 ? (busy0 || done0) : (busy1 || done1)) begin
      if (n++ > 200) begin
        checks++;
        errors++;
        $display("FAIL idle_timeout dut%0d: busy after 200 cycles, expected idle", id);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic sweep(input int id, input logic [3:0] tt);
    wait_idle(id);
    if (id == 0) begin
      tt0 = tt;
      q0.push_back(model(tt, (1 << E0) - 1, cyc, H0));
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
    end else begin
      tt1 = tt;
      q1.push_back(model(tt, (1 << E1) - 1, cyc, H1));
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
    end
  endtask

  // Monitor for dut0
  initial begin
    int unsigned k = 0;
    int unsigned bad = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        k = 0;
        bad = 0;
      end else begin
        chk("busy_done_excl0", 32'(busy0 & done0), 0);
        if (busy0) begin
          if ({a0, b0} != 2'(k / H0)) bad++;
          k++;
        end else chk("idle_ab0", 32'({a0, b0}), 0);
        if (done0) begin
          if (q0.size() == 0) chk("unexpected_done0", 1, 0);
          else begin
            e = q0.pop_front();
            chk("done_cycle0", cyc, e.done_cyc);
            chk("err_cnt0", 32'(ec0), e.err);
            chk("first_err_valid0", 32'(fev0), 32'(e.fv));
            chk("first_err_vec0", 32'(fvec0), 32'(e.fvec));
            chk("pass0", 32'(pass0), 32'(e.pass));
            chk("seq_len0", k, 4 * H0);
            chk("seq_vals0", bad, 0);
          end
          k = 0;
          bad = 0;
        end
      end
    end
  end

  // Monitor for dut1
  initial begin
    int unsigned k = 0;
    int unsigned bad = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        k = 0;
        bad = 0;
      end else begin
        chk("busy_done_excl1", 32'(busy1 & done1), 0);
        if (busy1) begin
          if ({a1, b1} != 2'(k / H1)) bad++;
          k++;
        end else chk("idle_ab1", 32'({a1, b1}), 0);
        if (done1) begin
          if (q1.size() == 0) chk("unexpected_done1", 1, 0);
          else begin
            e = q1.pop_front();
            chk("done_cycle1", cyc, e.done_cyc);
            chk("err_cnt1", 32'(ec1), e.err);
            chk("first_err_valid1", 32'(fev1), 32'(e.fv));
            chk("first_err_vec1", 32'(fvec1), 32'(e.fvec));
            chk("pass1", 32'(pass1), 32'(e.pass));
            chk("seq_len1", k, 4 * H1);
            chk("seq_vals1", bad, 0);
          end
          k = 0;
          bad = 0;
        end
      end
    end
  end

  initial begin
    int n;
    int unsigned c;
    rst = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    tt0 = 4'b0111;
    tt1 = 4'b0111;
    repeat (3) @(negedge clk);
    chk("rst_a0", 32'(a0), 0);
    chk("rst_b0", 32'(b0), 0);
    chk("rst_busy0", 32'(busy0), 0);
    chk("rst_done0", 32'(done0), 0);
    chk("rst_pass0", 32'(pass0), 0);
    chk("rst_err_cnt0", 32'(ec0), 0);
    chk("rst_fev0", 32'(fev0), 0);
    chk("rst_fvec0", 32'(fvec0), 0);
    chk("rst_busy1", 32'(busy1), 0);
    chk("rst_err_cnt1", 32'(ec1), 0);
    rst = 1'b0;

    // Directed gates: good NAND, AND, stuck-at-1, stuck-at-0, then random tables
    sweep(0, 4'b0111);
    sweep(0, 4'b1000);
    sweep(0, 4'b1111);
    sweep(0, 4'b0000);
    repeat (10) sweep(0, 4'($urandom_range(0, 15)));

    // Reset while vector 10 is applied, with errors already counted
    sweep(0, 4'b1000);
    n = 0;
    while (!(a0 && !b0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("reach_vec10_timeout", 1, 0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_a0", 32'(a0), 0);
    chk("midrst_b0", 32'(b0), 0);
    chk("midrst_busy0", 32'(busy0), 0);
    chk("midrst_done0", 32'(done0), 0);
    chk("midrst_err_cnt0", 32'(ec0), 0);
    chk("midrst_fev0", 32'(fev0), 0);
    q0.delete();
    @(negedge clk);
    #1 rst = 1'b0;
    sweep(0, 4'b0111);

    // start held high: second sweep accepted in the idle cycle after done
    wait_idle(0);
    tt0 = 4'b1111;
    c = cyc;
    q0.push_back(model(tt0, (1 << E0) - 1, c, H0));
    q0.push_back(model(tt0, (1 << E0) - 1, c + 4 * H0 + 2, H0));
    start0 = 1'b1;
    repeat (4 * H0 + 4) @(negedge clk);
    start0 = 1'b0;

    // Narrow counter and single-cycle hold
    sweep(1, 4'b1000);
    sweep(1, 4'b0111);
    sweep(1, 4'b1111);
    repeat (6) sweep(1, 4'($urandom_range(0, 15)));

    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("pending_expectations", 32'(q0.size() + q1.size()), 0);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
